// File: rtl/pulse2edge.sv
//==============================================================================
// Module      : pulse2edge
// Description : Converts single-cycle spike pulses on N_LINES independent
//               lines into gamma-framed edges and records each line's
//               first-spike tick within every gamma cycle.
//
//               A local tick counter divides time into gamma cycles of
//               GAMMA_LEN aclk cycles. Ticks 0..GAMMA_LEN-2 form the capture
//               window; tick GAMMA_LEN-1 is the reset phase, where the edges
//               drop, the captured first-spike times are published and the
//               capture registers are cleared for the next gamma.
//
// Ports       : aclk          unit clock, all state on its rising edge
//               rst           synchronous active-high reset
//               pulse_input   1-cycle spike pulses, one bit per line
//               edge_output   per-line edge, high from first spike to gamma end
//               gamma_start   high while tick == 0
//               spike_time    previous gamma's first-spike tick per line,
//                             line i at [i*TW +: TW], all-ones = no spike
//               spike_valid   line spiked in the previous gamma
//               result_valid  1-cycle strobe on the tick where results update
//               late_pulse    sticky flag: a pulse arrived on the reset phase
//
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module pulse2edge #(
  parameter int N_LINES   = 8,
  parameter int GAMMA_LEN = 16
) (
  input  logic                                   aclk,
  input  logic                                   rst,
  input  logic [N_LINES-1:0]                     pulse_input,
  output logic [N_LINES-1:0]                     edge_output,
  output logic                                   gamma_start,
  output logic [N_LINES*$clog2(GAMMA_LEN)-1:0]   spike_time,
  output logic [N_LINES-1:0]                     spike_valid,
  output logic                                   result_valid,
  output logic                                   late_pulse
);

  localparam int TW = $clog2(GAMMA_LEN);

  localparam logic [TW-1:0] c_tick_zero = '0;
  localparam logic [TW-1:0] c_tick_last = TW'(GAMMA_LEN - 1);
  localparam logic [TW-1:0] c_time_inf  = '1;

  //--------------------------------------------------------------------------
  // State
  //--------------------------------------------------------------------------
  logic [TW-1:0]      tick_q,         tick_d;
  logic [N_LINES-1:0] edge_q,         edge_d;
  logic [N_LINES-1:0] cap_hit_q,      cap_hit_d;
  logic [TW-1:0]      cap_time_q      [N_LINES];
  logic [TW-1:0]      cap_time_d      [N_LINES];
  logic [TW-1:0]      spike_time_q    [N_LINES];
  logic [TW-1:0]      spike_time_d    [N_LINES];
  logic [N_LINES-1:0] spike_valid_q,  spike_valid_d;
  logic               result_valid_q, result_valid_d;
  logic               late_pulse_q,   late_pulse_d;

  logic               reset_phase;
  logic [N_LINES-1:0] first_spike;

  //--------------------------------------------------------------------------
  // Tick counter: wraps from the reset-phase tick straight back to zero.
  //--------------------------------------------------------------------------
  assign reset_phase = (tick_q == c_tick_last);

  always_comb begin
    tick_d = tick_q + 1'b1;
    if (reset_phase) begin
      tick_d = c_tick_zero;
    end
  end

  //--------------------------------------------------------------------------
  // Edges: OR in new pulses during the capture window, drop everything at
  // the reset phase so each gamma begins with all edges low. Repeat pulses
  // on an already-high line leave the edge unchanged.
  //--------------------------------------------------------------------------
  always_comb begin
    edge_d = edge_q | pulse_input;
    if (reset_phase) begin
      edge_d = '0;
    end
  end

  // A line's first spike of the gamma is a pulse on a line not yet captured,
  // inside the capture window.
  assign first_spike = pulse_input & ~cap_hit_q & {N_LINES{~reset_phase}};

  //--------------------------------------------------------------------------
  // Capture and publish. At the reset phase the capture registers are
  // copied out (uncaptured lines report infinity) and then cleared.
  //--------------------------------------------------------------------------
  always_comb begin
    cap_hit_d      = cap_hit_q;
    spike_valid_d  = spike_valid_q;
    result_valid_d = 1'b0;
    late_pulse_d   = late_pulse_q;
    for (int i = 0; i < N_LINES; i++) begin
      cap_time_d[i]   = cap_time_q[i];
      spike_time_d[i] = spike_time_q[i];
    end

    if (reset_phase) begin
      result_valid_d = 1'b1;
      spike_valid_d  = cap_hit_q;
      cap_hit_d      = '0;
      // Pulses on the reset phase are not captured, only flagged.
      if (|pulse_input) begin
        late_pulse_d = 1'b1;
      end
      for (int i = 0; i < N_LINES; i++) begin
        spike_time_d[i] = cap_hit_q[i] ? cap_time_q[i] : c_time_inf;
        cap_time_d[i]   = c_tick_zero;
      end
    end else begin
      cap_hit_d = cap_hit_q | first_spike;
      for (int i = 0; i < N_LINES; i++) begin
        if (first_spike[i]) begin
          cap_time_d[i] = tick_q;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Registers
  //--------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (rst) begin
      tick_q         <= c_tick_zero;
      edge_q         <= '0;
      cap_hit_q      <= '0;
      spike_valid_q  <= '0;
      result_valid_q <= 1'b0;
      late_pulse_q   <= 1'b0;
      for (int i = 0; i < N_LINES; i++) begin
        cap_time_q[i]   <= c_tick_zero;
        spike_time_q[i] <= c_time_inf;
      end
    end else begin
      tick_q         <= tick_d;
      edge_q         <= edge_d;
      cap_hit_q      <= cap_hit_d;
      spike_valid_q  <= spike_valid_d;
      result_valid_q <= result_valid_d;
      late_pulse_q   <= late_pulse_d;
      for (int i = 0; i < N_LINES; i++) begin
        cap_time_q[i]   <= cap_time_d[i];
        spike_time_q[i] <= spike_time_d[i];
      end
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign edge_output  = edge_q;
  assign gamma_start  = (tick_q == c_tick_zero);
  assign spike_valid  = spike_valid_q;
  assign result_valid = result_valid_q;
  assign late_pulse   = late_pulse_q;

  for (genvar gi = 0; gi < N_LINES; gi++) begin : g_pack
    assign spike_time[gi*TW +: TW] = spike_time_q[gi];
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse2edge.sv
//==============================================================================
// Module      : tb_pulse2edge
// Description : Self-checking bench for pulse2edge (N_LINES=4, GAMMA_LEN=8).
//               A cycle-position model tracks, per line, the tick of the
//               first spike in the current gamma; outputs are derived from
//               that and compared every cycle, alongside hand-computed
//               directed expectations.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_pulse2edge;

  localparam int N  = 4;
  localparam int G  = 8;
  localparam int TW = 3;

  logic              aclk;
  logic              rst;
  logic [N-1:0]      pulse_input;
  logic [N-1:0]      edge_output;
  logic              gamma_start;
  logic [N*TW-1:0]   spike_time;
  logic [N-1:0]      spike_valid;
  logic              result_valid;
  logic              late_pulse;

  int n_chk = 0;
  int n_err = 0;

  pulse2edge #(
    .N_LINES   (N),
    .GAMMA_LEN (G)
  ) dut (
    .aclk         (aclk),
    .rst          (rst),
    .pulse_input  (pulse_input),
    .edge_output  (edge_output),
    .gamma_start  (gamma_start),
    .spike_time   (spike_time),
    .spike_valid  (spike_valid),
    .result_valid (result_valid),
    .late_pulse   (late_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  //--------------------------------------------------------------------------
  // Reference model: position in gamma, first-spike tick per line (-1 = none),
  // last published result, strobe and sticky late flag.
  //--------------------------------------------------------------------------
  int     m_tick;
  int     m_first [N];
  int     m_rtime [N];
  bit [N-1:0] m_rvalid;
  bit     m_rv;
  bit     m_late;
  bit     m_live = 1'b0;

  initial begin
    forever begin
      @(posedge aclk);
      if (rst) begin
        m_tick   = 0;
        m_rvalid = '0;
        m_rv     = 1'b0;
        m_late   = 1'b0;
        for (int i = 0; i < N; i++) begin
          m_first[i] = -1;
          m_rtime[i] = (1 << TW) - 1;
        end
        m_live = 1'b1;
      end else if (m_live) begin
        if (m_tick == G - 1) begin
          if (pulse_input != '0) m_late = 1'b1;
          for (int i = 0; i < N; i++) begin
            m_rvalid[i] = (m_first[i] >= 0);
            m_rtime[i]  = (m_first[i] >= 0) ? m_first[i] : (1 << TW) - 1;
            m_first[i]  = -1;
          end
          m_rv   = 1'b1;
          m_tick = 0;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (pulse_input[i] && m_first[i] < 0) m_first[i] = m_tick;
          end
          m_rv   = 1'b0;
          m_tick = m_tick + 1;
        end
      end
    end
  end

  // Compare process: every cycle, sampled on the falling edge.
  initial begin
    logic [N-1:0]    e_edge;
    logic [N*TW-1:0] e_st;
    forever begin
      @(negedge aclk);
      if (m_live) begin
        for (int i = 0; i < N; i++) begin
          e_edge[i]          = (m_first[i] >= 0);
          e_st[i*TW +: TW]   = TW'(m_rtime[i]);
        end
        chk("edge_output",  32'(edge_output),  32'(e_edge));
        chk("gamma_start",  32'(gamma_start),  32'(m_tick == 0));
        chk("spike_time",   32'(spike_time),   32'(e_st));
        chk("spike_valid",  32'(spike_valid),  32'(m_rvalid));
        chk("result_valid", 32'(result_valid), 32'(m_rv));
        chk("late_pulse",   32'(late_pulse),   32'(m_late));
      end
    end
  end

  // Drive one cycle's pulses, then land on the next falling edge.
  task automatic cyc(input logic [N-1:0] p);
    pulse_input = p;
    @(negedge aclk);
  endtask

  //--------------------------------------------------------------------------
  // Directed stimulus with literal expectations, then random traffic.
  //--------------------------------------------------------------------------
  initial begin
    rst         = 1'b1;
    pulse_input = '0;
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_gamma_start",  32'(gamma_start),  32'd1);
    chk("rst_edge",         32'(edge_output),  32'd0);
    chk("rst_spike_time",   32'(spike_time),   32'hFFF);
    chk("rst_spike_valid",  32'(spike_valid),  32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_late",         32'(late_pulse),   32'd0);
    rst = 1'b0;

    // Gamma A: idle.
    cyc('0);
    chk("A_gamma_start_t1", 32'(gamma_start), 32'd0);
    chk("A_no_early_rv",    32'(result_valid), 32'd0);
    repeat (7) cyc('0);
    chk("A_rv",  32'(result_valid), 32'd1);
    chk("A_sv",  32'(spike_valid),  32'd0);
    chk("A_st",  32'(spike_time),   32'hFFF);
    chk("A_gs",  32'(gamma_start),  32'd1);

    // Gamma B: line0 at tick 2.
    repeat (2) cyc('0);
    cyc(4'b0001);
    chk("B_edge_t3", 32'(edge_output), 32'b0001);
    repeat (4) cyc('0);
    chk("B_edge_t7", 32'(edge_output), 32'b0001);
    cyc('0);
    chk("B_edge_t0", 32'(edge_output), 32'b0000);
    chk("B_rv",      32'(result_valid), 32'd1);
    chk("B_sv",      32'(spike_valid),  32'b0001);
    chk("B_st",      32'(spike_time),   32'hFFA);

    // Gamma C: lines 1,3 at tick 0; line1 again at tick 5.
    cyc(4'b1010);
    chk("C_edge_t1", 32'(edge_output), 32'b1010);
    chk("C_rv_off",  32'(result_valid), 32'd0);
    repeat (4) cyc('0);
    cyc(4'b0010);
    chk("C_edge_t6", 32'(edge_output), 32'b1010);
    repeat (2) cyc('0);
    chk("C_sv", 32'(spike_valid), 32'b1010);
    chk("C_st", 32'(spike_time),  32'h1C7);

    // Gamma D: line2 at tick 6, then at tick 7 (late).
    repeat (6) cyc('0);
    cyc(4'b0100);
    chk("D_edge_t7", 32'(edge_output), 32'b0100);
    chk("D_late_0",  32'(late_pulse),  32'd0);
    cyc(4'b0100);
    chk("D_edge_t0", 32'(edge_output), 32'b0000);
    chk("D_late_1",  32'(late_pulse),  32'd1);
    chk("D_sv",      32'(spike_valid), 32'b0100);
    chk("D_st",      32'(spike_time),  32'hFBF);

    // Gamma E: line0 at tick 1, reset at tick 4.
    cyc('0);
    cyc(4'b0001);
    repeat (2) cyc('0);
    chk("E_late_sticky", 32'(late_pulse), 32'd1);
    rst = 1'b1;
    cyc('0);
    chk("E_rst_edge", 32'(edge_output), 32'd0);
    chk("E_rst_late", 32'(late_pulse),  32'd0);
    chk("E_rst_gs",   32'(gamma_start), 32'd1);
    rst = 1'b0;
    repeat (8) cyc('0);
    chk("E_post_rv", 32'(result_valid), 32'd1);
    chk("E_post_sv", 32'(spike_valid),  32'd0);
    chk("E_post_st", 32'(spike_time),   32'hFFF);

    // Random traffic over 50 gammas, checked by the model.
    for (int k = 0; k < 50 * G; k++) begin
      cyc(N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
    end
    pulse_input = '0;
    @(negedge aclk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
